// File: rtl/seven_seg_bank.sv
// Registered multi-digit seven-segment driver: glyph register file with addressed
// write and scroll-in, per-digit blink, leading-zero blanking, active-low output bus.
module seven_seg_bank #(
    parameter int NUM_DIGITS = 8,
    parameter int ADDR_W     = 3,
    parameter int BLINK_DIV  = 25000000,
    parameter int CNT_W      = 25
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [4:0]              wr_data,
    input  logic                    shift_en,
    input  logic [4:0]              shift_data,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    blank_lz,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic                    blink_phase
);

    localparam int unsigned ND = NUM_DIGITS;
    localparam logic [4:0] CODE_BLANK = 5'd31;

    logic [4:0]             digit [ND];
    logic [CNT_W-1:0]       blink_cnt;
    logic [7*ND-1:0]        next_seg;
    logic                   live;
    logic                   dark;
    int unsigned            idx;

    function automatic logic [6:0] decode(input logic [4:0] code);
        case (code)
            5'd0:    decode = 7'b1000000;
            5'd1:    decode = 7'b1111001;
            5'd2:    decode = 7'b0100100;
            5'd3:    decode = 7'b0110000;
            5'd4:    decode = 7'b0011001;
            5'd5:    decode = 7'b0010010;
            5'd6:    decode = 7'b0000010;
            5'd7:    decode = 7'b1111000;
            5'd8:    decode = 7'b0000000;
            5'd9:    decode = 7'b0011000;
            5'd10:   decode = 7'b0001000;
            5'd11:   decode = 7'b0000011;
            5'd12:   decode = 7'b1000110;
            5'd13:   decode = 7'b0100001;
            5'd14:   decode = 7'b0000110;
            5'd15:   decode = 7'b0001110;
            5'd16:   decode = 7'b1000010;
            5'd17:   decode = 7'b0001001;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // Scan from the most significant digit down; live goes high once a digit
    // showing a visible non-zero glyph has been seen, ending leading-zero blanking.
    always_comb begin
        next_seg = '1;
        live     = 1'b0;
        dark     = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < ND; k++) begin
            idx  = ND - 1 - k;
            dark = blink_phase && blink_mask[idx];
            if (blank_lz && idx != 0 && digit[idx] == 5'd0 && !live)
                dark = 1'b1;
            if (digit[idx] != 5'd0 && digit[idx] < 5'd18)
                live = 1'b1;
            next_seg[7*idx +: 7] = dark ? 7'b1111111 : decode(digit[idx]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < ND; i++)
                digit[i] <= CODE_BLANK;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            seg_out     <= '1;
        end else begin
            if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            if (shift_en) begin
                for (int unsigned i = 1; i < ND; i++)
                    digit[i] <= digit[i-1];
                digit[0] <= shift_data;
            end else if (wr_en && 32'(wr_addr) < ND) begin
                digit[wr_addr] <= wr_data;
            end

            seg_out <= next_seg;
        end
    end

endmodule
